// File: rtl/pht_update.sv
// Pattern history table with a pending-branch queue; resolves train 2-bit counters.
// Optional mispredict counter guarded by macro PHT_MISPRED_CNT_EN (default: absent, mp_cnt tied to 0).
module pht_update #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        brnch,
    input  logic [3:0]  idx,
    input  logic        res_vld,
    input  logic        res_taken,
    output logic [15:0] pred_bits,
    output logic        mispred,
    output logic        ovf,
    output logic        udf,
    output logic [4:0]  pend_cnt,
    output logic [7:0]  mp_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    ctr_q   [16];
    logic [1:0]    ctr_d   [16];
    logic [3:0]    qidx_q  [DEPTH];
    logic          qpred_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [4:0]    pend_cnt_q, pend_cnt_d;
    logic          mispred_q, mispred_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          q_empty, q_full, pop, push;
    logic [3:0]    hidx;
    logic          hpred;

    always_comb begin
        q_empty    = (pend_cnt_q == 5'd0);
        q_full     = (pend_cnt_q == 5'(DEPTH));
        pop        = res_vld && !q_empty;
        // A full queue still accepts a push when the head leaves on the same edge.
        push       = brnch && (!q_full || pop);
        hidx       = qidx_q[head_q];
        hpred      = qpred_q[head_q];
        pend_cnt_d = pend_cnt_q + {4'd0, push} - {4'd0, pop};
        mispred_d  = pop && (hpred != res_taken);
        ovf_d      = brnch && !push;
        udf_d      = res_vld && q_empty;
        ctr_d      = ctr_q;
        if (pop) begin
            if (res_taken) begin
                if (ctr_q[hidx] != 2'b11) ctr_d[hidx] = ctr_q[hidx] + 2'd1;
            end else begin
                if (ctr_q[hidx] != 2'b00) ctr_d[hidx] = ctr_q[hidx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ctr_q[i] <= 2'b01;
            for (int i = 0; i < DEPTH; i++) begin
                qidx_q[i]  <= 4'd0;
                qpred_q[i] <= 1'b0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            pend_cnt_q <= 5'd0;
            mispred_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            if (push) begin
                // Pre-edge predict bit, even if this edge also trains ctr[idx].
                qidx_q[tail_q]  <= idx;
                qpred_q[tail_q] <= ctr_q[idx][1];
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            pend_cnt_q <= pend_cnt_d;
            mispred_q  <= mispred_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_pred
        assign pred_bits[g] = ctr_q[g][1];
    end

    assign mispred  = mispred_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign pend_cnt = pend_cnt_q;

`ifdef PHT_MISPRED_CNT_EN
    logic [7:0] mp_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mp_cnt_q <= 8'h00;
        end else if (mispred_d && (mp_cnt_q != 8'hFF)) begin
            mp_cnt_q <= mp_cnt_q + 8'd1;
        end
    end

    assign mp_cnt = mp_cnt_q;
`else
    assign mp_cnt = 8'h00;
`endif

endmodule

// File: doc/pht_update.md
PHT_UPDATE -- requirements
Module: pht_update

Interface
REQ-001 Parameter DEPTH, default 4, pending-branch queue depth; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 brnch  input  1  prediction event; the downstream predictor consumed pred_bits this cycle.
REQ-005 idx  input  4  history-XOR-address index used for this prediction.
REQ-006 res_vld  input  1  oldest outstanding branch resolved this cycle.
REQ-007 res_taken  input  1  resolved outcome: 1 = taken.
REQ-008 pred_bits  output  16  per-entry predict bit, the MSB of each 2-bit counter; drives the predictor's table input.
REQ-009 mispred  output  1  one-cycle pulse: the resolved branch was mispredicted.
REQ-010 ovf  output  1  one-cycle pulse: brnch was dropped because the queue was full.
REQ-011 udf  output  1  one-cycle pulse: res_vld arrived with the queue empty.
REQ-012 pend_cnt  output  5  number of outstanding branches, 0..DEPTH.
REQ-013 mp_cnt  output  8  mispredict count; present per REQ-030.

Function
REQ-014 Table: 16 two-bit saturating counters ctr[0..15]; pred_bits[i] = ctr[i][1], driven directly from registers.
REQ-015 Push: on brnch with pend_cnt<DEPTH, write {idx, pred_bits[idx]} at the tail; tail advances modulo DEPTH.
REQ-016 The pushed predict bit is the pre-edge pred_bits value, even if the same edge updates ctr[idx].
REQ-017 Pop: on res_vld with pend_cnt>0, read the head entry {hidx, hpred}; head advances modulo DEPTH.
REQ-018 Update on pop: res_taken=1 sets ctr[hidx] to min(ctr+1,3); res_taken=0 sets ctr[hidx] to max(ctr-1,0).
REQ-019 Latency: the new pred_bits value is visible one cycle after the res_vld edge.
REQ-020 On pop, mispred is registered high for exactly one cycle when hpred != res_taken.
REQ-021 Full: brnch with pend_cnt=DEPTH and no same-cycle pop is dropped; ovf pulses; no state change.
REQ-022 Full with simultaneous pop: push and pop both accepted; pend_cnt stays DEPTH.
REQ-023 Empty: res_vld with pend_cnt=0 is ignored (no counter update) and udf pulses, even if brnch pushes in the same cycle.
REQ-024 Simultaneous push and pop at 0<pend_cnt<DEPTH: both performed; pend_cnt unchanged.
REQ-025 res_taken is ignored when res_vld=0; idx is ignored when brnch=0.

Reset
REQ-026 rst asserted sets every ctr to 2'b01 (weakly not-taken), so pred_bits=16'h0000.
REQ-027 rst asserted clears the head/tail pointers and sets pend_cnt=0, mispred=0, ovf=0, udf=0, mp_cnt=0.
REQ-028 rst takes effect immediately, independent of clk; mid-operation it discards every pending entry.
REQ-029 The first active edge after rst deassertion operates normally.

Configuration
REQ-030 Macro PHT_MISPRED_CNT_EN.
- Defined: mp_cnt increments once per mispred pulse and saturates at 8'hFF.
- Undefined: mp_cnt is tied to 8'h00 and no counter register is built.

Verification
REQ-031 Reset, then brnch idx=5 ×3 at one per cycle, then res_vld res_taken=1 ×2 -> pred_bits[5]: 0 then 1; second resolve gives mispred=1; pend_cnt=1.
REQ-032 Drive idx=3 to saturation: 4 push/resolve-taken pairs -> ctr[3]=3; one not-taken -> ctr[3]=2 and pred_bits[3]=1; a second not-taken -> pred_bits[3]=0.
REQ-033 DEPTH=4: 5 consecutive brnch without resolves -> pend_cnt=4; ovf pulses on the 5th; next brnch together with res_vld -> both accepted, pend_cnt=4.
REQ-034 res_vld at pend_cnt=0 with brnch in the same cycle -> udf=1; no counter change; pend_cnt=1.
REQ-035 Assert rst asynchronously between edges with pend_cnt=3 and ctr[7]=3 -> pend_cnt=0 and pred_bits=0 immediately; a resolve after release gives udf.
REQ-036 PHT_MISPRED_CNT_EN defined, 300 mispredicts -> mp_cnt=8'hFF; undefined -> mp_cnt stays 0.
